reset_sequencer: RTL



---
 rtl/reset_seq_pkg.sv | 21 ++
 rtl/reset_sequencer_if.sv | 32 +++
 rtl/reset_sync.sv | 22 ++
 rtl/reset_sequencer.sv | 125 ++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types, defaults and width helpers for the aes128 core reset sequencer.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    StInit,
    StHold,
    StRun,
    StDrain,
    StAssert
  } rst_state_e;

  localparam int unsigned DefSyncStages    = 2;
  localparam int unsigned DefHoldCycles    = 16;
  localparam int unsigned DefTimeoutCycles = 64;

  // Bits needed to hold every value in 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Soft-reset / quiesce handshake and reset outputs between the sequencer and the core.
interface reset_sequencer_if;

  logic sw_rst_req;
  logic quiesce_ack;
  logic rstb_out;
  logic rst_done;
  logic quiesce_req;
  logic busy;
  logic timeout_flag;

  modport master (
    input  sw_rst_req,
    input  quiesce_ack,
    output rstb_out,
    output rst_done,
    output quiesce_req,
    output busy,
    output timeout_flag
  );

  modport slave (
    output sw_rst_req,
    output quiesce_ack,
    input  rstb_out,
    input  rst_done,
    input  quiesce_req,
    input  busy,
    input  timeout_flag
  );

endinterface

// File: rtl/reset_sync.sv
// RSTB release synchroniser: asserts asynchronously, releases after STAGES edges.
module reset_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic CLK,
  input  logic RSTB,
  output logic sync_rstb
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], 1'b1};
    end
  end

  assign sync_rstb = chain_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Power-on and software reset sequencer for the aes128 core: sync release, hold stretch,
// quiesce handshake with timeout. All outputs come straight from flops.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = DefSyncStages,
  parameter int unsigned HOLD_CYCLES    = DefHoldCycles,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input logic               CLK,
  input logic               RSTB,
  reset_sequencer_if.master bus
);

  localparam int unsigned HoldW = cnt_width(HOLD_CYCLES);
  localparam int unsigned TmoW  = cnt_width(TIMEOUT_CYCLES);

  logic             sync_rstb;
  rst_state_e       state_q, state_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic [TmoW-1:0]  timer_q, timer_d;
  logic             rstb_out_q, rstb_out_d;
  logic             rst_done_q, rst_done_d;
  logic             quiesce_req_q, quiesce_req_d;
  logic             busy_q, busy_d;
  logic             timeout_flag_q, timeout_flag_d;

  reset_sync #(
    .STAGES (SYNC_STAGES)
  ) u_reset_sync (
    .CLK       (CLK),
    .RSTB      (RSTB),
    .sync_rstb (sync_rstb)
  );

  always_comb begin
    state_d        = state_q;
    hold_cnt_d     = hold_cnt_q;
    timer_d        = timer_q;
    timeout_flag_d = timeout_flag_q;

    unique case (state_q)
      StInit: begin
        if (sync_rstb) begin
          // The edge that sees the synchroniser release already counts as the first hold cycle.
          if (HOLD_CYCLES == 1) begin
            state_d = StRun;
          end else begin
            state_d    = StHold;
            hold_cnt_d = HoldW'(1);
          end
        end
      end
      StHold: begin
        if (hold_cnt_q == HoldW'(HOLD_CYCLES - 1)) begin
          state_d    = StRun;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end
      StRun: begin
        if (bus.sw_rst_req) begin
          state_d        = StDrain;
          timer_d        = '0;
          timeout_flag_d = 1'b0;
        end
      end
      StDrain: begin
        // An ACK arriving on the timeout edge wins; the flag stays clear.
        if (bus.quiesce_ack) begin
          state_d = StAssert;
          timer_d = '0;
        end else if (timer_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
          state_d        = StAssert;
          timer_d        = '0;
          timeout_flag_d = 1'b1;
        end else begin
          timer_d = timer_q + TmoW'(1);
        end
      end
      StAssert: begin
        state_d    = StHold;
        hold_cnt_d = '0;
      end
      default: begin
        state_d = StInit;
      end
    endcase

    rstb_out_d    = (state_d == StRun) || (state_d == StDrain);
    rst_done_d    = (state_d == StRun) && (state_q != StRun);
    quiesce_req_d = (state_d == StDrain);
    busy_d        = (state_d != StRun);
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q        <= StInit;
      hold_cnt_q     <= '0;
      timer_q        <= '0;
      rstb_out_q     <= 1'b0;
      rst_done_q     <= 1'b0;
      quiesce_req_q  <= 1'b0;
      busy_q         <= 1'b1;
      timeout_flag_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      timer_q        <= timer_d;
      rstb_out_q     <= rstb_out_d;
      rst_done_q     <= rst_done_d;
      quiesce_req_q  <= quiesce_req_d;
      busy_q         <= busy_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end

  assign bus.rstb_out     = rstb_out_q;
  assign bus.rst_done     = rst_done_q;
  assign bus.quiesce_req  = quiesce_req_q;
  assign bus.busy         = busy_q;
  assign bus.timeout_flag = timeout_flag_q;

endmodule
